// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: machine word, fetch FSM states and the IF/ID payload.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t PC_STEP = WORD_W'(4);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // One fetched instruction together with its link/branch-base address.
   typedef struct packed {
      word_t instr;
      word_t npc;
   } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: icache port, hazard/redirect controls and IF/ID outputs.
interface fetch_unit_if;
   import cpu_types_pkg::*;

   logic  ihit;
   word_t iload;
   logic  iREN;
   word_t iaddr;
   logic  stall;
   logic  flush;
   logic  redirect;
   word_t redirect_pc;
   logic  halt;
   word_t instr;
   word_t npc;
   logic  valid;
   word_t fetch_count;

   modport master (
      input  ihit, iload, stall, flush, redirect, redirect_pc, halt,
      output iREN, iaddr, instr, npc, valid, fetch_count
   );

   modport slave (
      output ihit, iload, stall, flush, redirect, redirect_pc, halt,
      input  iREN, iaddr, instr, npc, valid, fetch_count
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry hold buffer for stalled hits, IF/ID latch
// and an accepted-instruction counter, sequenced by a FETCH/HOLD/HALTED FSM.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  fif
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   ifid_t        ifid_q, ifid_d;
   logic         valid_q, valid_d;
   word_t        count_q, count_d;
   ifid_t        hold_q, hold_d;

   word_t        pc_plus4;

   assign pc_plus4 = pc_q + PC_STEP;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
         ifid_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         valid_q <= valid_d;
         count_q <= count_d;
         hold_q  <= hold_d;
      end
   end

   // Next state: redirect > halt > flush > stall > ihit; HALTED is sticky until reset.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      valid_d = valid_q;
      count_d = count_q;
      hold_d  = hold_q;

      if (state_q != HALTED) begin
         if (fif.redirect) begin
            pc_d    = fif.redirect_pc;
            hold_d  = '0;
            valid_d = 1'b0;
            state_d = FETCH;
         end else if (fif.halt) begin
            valid_d = 1'b0;
            state_d = HALTED;
         end else if (fif.flush) begin
            valid_d = 1'b0;
            hold_d  = '0;
            state_d = FETCH;
            if (state_q == FETCH && fif.ihit) begin
               pc_d = pc_plus4;
            end
         end else if (fif.stall) begin
            // A hit during a stall is parked so the icache request is not lost.
            if (state_q == FETCH && fif.ihit) begin
               hold_d  = '{instr: fif.iload, npc: pc_plus4};
               pc_d    = pc_plus4;
               state_d = HOLD;
            end
         end else if (state_q == HOLD) begin
            ifid_d  = hold_q;
            valid_d = 1'b1;
            count_d = count_q + WORD_W'(1);
            hold_d  = '0;
            state_d = FETCH;
         end else if (fif.ihit) begin
            ifid_d  = '{instr: fif.iload, npc: pc_plus4};
            valid_d = 1'b1;
            count_d = count_q + WORD_W'(1);
            pc_d    = pc_plus4;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   assign fif.iREN        = (state_q == FETCH);
   assign fif.iaddr       = pc_q;
   assign fif.instr       = ifid_q.instr;
   assign fif.npc         = ifid_q.npc;
   assign fif.valid       = valid_q;
   assign fif.fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, reset PC; core 1 instantiates 32'h0000_0200.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 ihit  in  1  icache returns iload for iaddr this cycle.
REQ-005 iload  in  32  instruction word from icache.
REQ-006 iREN  out  1  instruction read request.
REQ-007 iaddr  out  32  fetch address, equal to current PC.
REQ-008 stall  in  1  hazard unit holds IF/ID contents.
REQ-009 flush  in  1  squashes IF/ID (valid to 0).
REQ-010 redirect  in  1  taken branch/jump/JR from a later stage.
REQ-011 redirect_pc  in  32  target address for redirect.
REQ-012 halt  in  1  HALT decoded by control unit; freezes fetch.
REQ-013 instr  out  32  IF/ID instruction word feeding the decoder (op/funct fields).
REQ-014 npc  out  32  IF/ID PC+4 of instr (JAL link value, branch base).
REQ-015 valid  out  1  instr is a real instruction, not a bubble.
REQ-016 fetch_count  out  32  instructions accepted into IF/ID since reset.

Function
REQ-017 States FETCH, HOLD, HALTED; iREN=1 only in FETCH; iaddr=pc in all states.
REQ-018 FETCH, ihit & !stall: instr<=iload, npc<=pc+4, valid<=1, pc<=pc+4, fetch_count+1; one-cycle latency ihit->instr.
REQ-019 FETCH, ihit & stall: iload captured in hold buffer with pc+4, pc<=pc+4, IF/ID unchanged, next state HOLD.
REQ-020 FETCH, !ihit & !stall: valid<=0 (bubble), pc unchanged.
REQ-021 FETCH, !ihit & stall: IF/ID and pc unchanged.
REQ-022 HOLD, !stall: IF/ID<=hold buffer, valid<=1, fetch_count+1, next FETCH; HOLD & stall: no change.
REQ-023 redirect (any state but HALTED): pc<=redirect_pc, hold buffer discarded, valid<=0, next FETCH; same-cycle ihit ignored, no count.
REQ-024 Priority: redirect > halt > flush > stall > ihit.
REQ-025 flush without redirect: valid<=0; pc advances if ihit, hold buffer discarded, next FETCH.
REQ-026 halt (no redirect): next HALTED, valid<=0; HALTED exits only on RST; redirect and ihit ignored.
REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0); fetch_count wraps modulo 2^32.
REQ-028 redirect_pc used as-is; no alignment correction.

Reset
REQ-029 RST asserted: pc=PC_INIT, state=FETCH, instr=0, npc=0, valid=0, fetch_count=0, hold buffer cleared, immediately and asynchronously.
REQ-030 RST mid-request or in HOLD drops the pending instruction; first post-reset request is to PC_INIT.
REQ-031 iREN=1 in first cycle after RST deassertion.

Structure
REQ-032 word_t and fetch_state_t (FETCH, HOLD, HALTED) in cpu_types_pkg; PC_STEP=4 constant in same package.
REQ-033 Single module; no sub-module: PC, hold buffer, IF/ID latch and counter inline, next-state logic in one combinational block.

Verification
REQ-034 Reset, ihit=1 continuous, iload=32'h2401_0005 -> iaddr 0,4,8; instr=32'h2401_0005, npc=4 one cycle after first ihit; fetch_count=3 after 3 hits.
REQ-035 ihit with stall=1 at pc=8, stall held 2 cycles -> state HOLD, iREN=0, iaddr=12; on stall release instr=buffered word, npc=12, valid=1.
REQ-036 redirect=1, redirect_pc=32'h0000_0040 while in HOLD -> buffer dropped, valid=0, next iaddr=32'h40, fetch_count unchanged.
REQ-037 halt=1 and redirect=1 same cycle -> redirect wins, iaddr=redirect_pc; halt alone next cycle -> HALTED, iREN=0, valid=0, ihit pulses ignored.
REQ-038 PC_INIT=32'h200, RST asserted mid-stall -> outputs zero asynchronously, iaddr=32'h200, iREN=1 after release.
REQ-039 redirect_pc=32'hFFFF_FFFC, ihit=1 -> npc=32'h0, next iaddr=32'h0.
